// File: rtl/wb_master_port_if.sv
// Core-side request/response and Wishbone B3 signals of the master port.
// master = port view, slave = core/interconnect view.
interface wb_master_port_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   localparam int SW   = DATA_W / 8;
   localparam int WA_W = ADDR_W - $clog2(SW);

   logic              req_valid;
   logic              req_ready;
   logic              req_we;
   logic [1:0]        req_size;
   logic [ADDR_W-1:0] req_addr;
   logic [DATA_W-1:0] req_wdata;

   logic              rsp_valid;
   logic              rsp_ready;
   logic [DATA_W-1:0] rsp_rdata;
   logic              rsp_err;
   logic              busy_o;

   logic [WA_W-1:0]   adr_o;
   logic [DATA_W-1:0] dat_o;
   logic [DATA_W-1:0] dat_i;
   logic [SW-1:0]     sel_o;
   logic              we_o;
   logic              cyc_o;
   logic              stb_o;
   logic              ack_i;
   logic              err_i;

   modport master (
      input  req_valid, req_we, req_size, req_addr, req_wdata, rsp_ready,
      input  dat_i, ack_i, err_i,
      output req_ready, rsp_valid, rsp_rdata, rsp_err, busy_o,
      output adr_o, dat_o, sel_o, we_o, cyc_o, stb_o
   );

   modport slave (
      output req_valid, req_we, req_size, req_addr, req_wdata, rsp_ready,
      output dat_i, ack_i, err_i,
      input  req_ready, rsp_valid, rsp_rdata, rsp_err, busy_o,
      input  adr_o, dat_o, sel_o, we_o, cyc_o, stb_o
   );
endinterface

// File: rtl/wb_master_port.sv
// Wishbone B3 master: FIFO-buffered byte..dword requests, one bus cycle and one response each.
// Latency: accept->cyc_o one edge; backpressure: req_ready low when FIFO full, response held until rsp_ready.
module fifo #(
   parameter int W     = 8,
   parameter int DEPTH = 2
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         push,
   input  logic [W-1:0] push_dat,
   output logic         full,
   input  logic         pop,
   output logic [W-1:0] pop_dat,
   output logic         empty
);
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [CW-1:0] cnt;
   logic          do_push;
   logic          do_pop;

   function automatic logic [AW-1:0] inc(input logic [AW-1:0] p);
      return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
   endfunction

   assign full    = (cnt == CW'(DEPTH));
   assign empty   = (cnt == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign pop_dat = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
      end else begin
         if (do_push) wr_ptr <= inc(wr_ptr);
         if (do_pop)  rd_ptr <= inc(rd_ptr);
         case ({do_push, do_pop})
            2'b10:   cnt <= cnt + CW'(1);
            2'b01:   cnt <= cnt - CW'(1);
            default: cnt <= cnt;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= push_dat;
   end
endmodule

module wb_master_port #(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int DEPTH   = 2,
   parameter int TIMEOUT = 255
) (
   input  logic            clk_i,
   input  logic            rst_i,
   wb_master_port_if.master bus
);
   localparam int SW = DATA_W / 8;
   localparam int OW = $clog2(SW);
   localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

   typedef struct packed {
      logic              we;
      logic [1:0]        size;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] wdata;
   } req_t;

   typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;

   state_t        state;
   req_t          push_dat;
   req_t          head;
   logic          full;
   logic          empty;
   logic          pop;

   logic [OW-1:0]     head_off;
   logic [SW-1:0]     head_sel;
   logic [DATA_W-1:0] head_dat;
   logic              head_bad;
   logic [OW-1:0]     cur_off;
   logic [1:0]        cur_size;
   logic [DATA_W-1:0] rd_val;
   logic [TW-1:0]     tcnt;
   logic [TW-1:0]     tcnt_nxt;
   logic              timeout_hit;

   function automatic logic [SW-1:0] byte_mask(input logic [1:0] size);
      logic [SW-1:0] m;
      m = '0;
      for (int i = 0; i < SW; i++) m[i] = (i < (1 << size));
      return m;
   endfunction

   function automatic logic [DATA_W-1:0] lane_mask(input logic [SW-1:0] sel);
      logic [DATA_W-1:0] m;
      m = '0;
      for (int b = 0; b < SW; b++) m[8*b +: 8] = {8{sel[b]}};
      return m;
   endfunction

   assign push_dat = '{we: bus.req_we, size: bus.req_size,
                       addr: bus.req_addr, wdata: bus.req_wdata};
   assign pop      = (state == IDLE) && !empty;

   fifo #(
      .W     ($bits(req_t)),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk      (clk_i),
      .rst      (rst_i),
      .push     (bus.req_valid),
      .push_dat (push_dat),
      .full     (full),
      .pop      (pop),
      .pop_dat  (head),
      .empty    (empty)
   );

   assign bus.req_ready = !full;
   assign bus.busy_o    = !empty || (state != IDLE);

   // Low-bit mask wraps to all-ones for the full-width size, so one expression covers every size.
   assign head_off = head.addr[OW-1:0];
   assign head_sel = byte_mask(head.size) << head_off;
   assign head_dat = (head.wdata << {head_off, 3'b000}) & lane_mask(head_sel);
   assign head_bad = ((DATA_W == 32) && (head.size == 2'd3)) ||
                     (|(head_off & ((OW'(1) << head.size) - OW'(1))));

   assign rd_val      = (bus.dat_i >> {cur_off, 3'b000}) & lane_mask(byte_mask(cur_size));
   assign tcnt_nxt    = tcnt + TW'(1);
   assign timeout_hit = (TIMEOUT != 0) && (tcnt_nxt == TW'(TIMEOUT));

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state         <= IDLE;
         bus.cyc_o     <= 1'b0;
         bus.stb_o     <= 1'b0;
         bus.we_o      <= 1'b0;
         bus.adr_o     <= '0;
         bus.dat_o     <= '0;
         bus.sel_o     <= '0;
         bus.rsp_valid <= 1'b0;
         bus.rsp_err   <= 1'b0;
         bus.rsp_rdata <= '0;
         tcnt          <= '0;
         cur_off       <= '0;
         cur_size      <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (!empty) begin
                  cur_off  <= head_off;
                  cur_size <= head.size;
                  if (head_bad) begin
                     bus.rsp_valid <= 1'b1;
                     bus.rsp_err   <= 1'b1;
                     bus.rsp_rdata <= '0;
                     state         <= RESP;
                  end else begin
                     bus.cyc_o <= 1'b1;
                     bus.stb_o <= 1'b1;
                     bus.adr_o <= head.addr[ADDR_W-1:OW];
                     bus.we_o  <= head.we;
                     bus.sel_o <= head_sel;
                     bus.dat_o <= head_dat;
                     tcnt      <= '0;
                     state     <= BUS;
                  end
               end
            end
            BUS: begin
               if (bus.err_i || bus.ack_i || timeout_hit) begin
                  bus.cyc_o     <= 1'b0;
                  bus.stb_o     <= 1'b0;
                  bus.rsp_valid <= 1'b1;
                  tcnt          <= '0;
                  state         <= RESP;
                  // err_i outranks a simultaneous ack_i; a timeout is reported as an error.
                  if (!bus.err_i && bus.ack_i) begin
                     bus.rsp_err   <= 1'b0;
                     bus.rsp_rdata <= bus.we_o ? '0 : rd_val;
                  end else begin
                     bus.rsp_err   <= 1'b1;
                     bus.rsp_rdata <= '0;
                  end
               end else begin
                  tcnt <= tcnt_nxt;
               end
            end
            RESP: begin
               if (bus.rsp_ready) begin
                  bus.rsp_valid <= 1'b0;
                  bus.rsp_err   <= 1'b0;
                  bus.rsp_rdata <= '0;
                  state         <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_wb_master_port.sv
// Directed bench for wb_master_port (DATA_W=32, DEPTH=2, TIMEOUT=4) with a response scoreboard.
module tb_wb_master_port;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_tests = 0;
   int   n_fail  = 0;

   typedef struct packed {
      logic [31:0] rdata;
      logic        err;
   } exp_t;
   exp_t q[$];

   wb_master_port_if #(.ADDR_W(32), .DATA_W(32)) bus ();

   wb_master_port #(
      .ADDR_W  (32),
      .DATA_W  (32),
      .DEPTH   (2),
      .TIMEOUT (4)
   ) dut (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, observed timeout required completion");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic we, input logic [1:0] size, input logic [31:0] addr,
                        input logic [31:0] wdata);
      bus.req_valid = 1'b1;
      bus.req_we    = we;
      bus.req_size  = size;
      bus.req_addr  = addr;
      bus.req_wdata = wdata;
   endtask

   task automatic send(input logic we, input logic [1:0] size, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [31:0] erd, input logic eerr);
      drive(we, size, addr, wdata);
      for (int i = 0; i < 20 && !bus.req_ready; i++) tick();
      chk("send_ready", bus.req_ready, 1);
      tick();
      bus.req_valid = 1'b0;
      q.push_back('{rdata: erd, err: eerr});
   endtask

   task automatic respond(input logic a, input logic e, input logic [31:0] d);
      bus.ack_i = a;
      bus.err_i = e;
      bus.dat_i = d;
      tick();
      bus.ack_i = 1'b0;
      bus.err_i = 1'b0;
   endtask

   task automatic wait_cyc(input string tag);
      for (int i = 0; i < 20 && !bus.cyc_o; i++) tick();
      chk(tag, bus.cyc_o, 1);
   endtask

   task automatic take_rsp(input string tag);
      exp_t e;
      for (int i = 0; i < 20 && !bus.rsp_valid; i++) tick();
      chk({tag, "_valid"}, bus.rsp_valid, 1);
      chk({tag, "_queued"}, q.size() > 0, 1);
      e = (q.size() > 0) ? q.pop_front() : '0;
      chk({tag, "_rdata"}, bus.rsp_rdata, e.rdata);
      chk({tag, "_err"}, bus.rsp_err, e.err);
      bus.rsp_ready = 1'b1;
      tick();
      bus.rsp_ready = 1'b0;
      chk({tag, "_valid_fall"}, bus.rsp_valid, 0);
   endtask

   initial begin
      int  hi;
      logic saw_cyc;
      bus.req_valid = 1'b0;
      bus.req_we    = 1'b0;
      bus.req_size  = 2'd0;
      bus.req_addr  = '0;
      bus.req_wdata = '0;
      bus.rsp_ready = 1'b0;
      bus.dat_i     = '0;
      bus.ack_i     = 1'b0;
      bus.err_i     = 1'b0;

      // Reset state
      tick();
      tick();
      chk("rst_cyc", bus.cyc_o, 0);
      chk("rst_stb", bus.stb_o, 0);
      chk("rst_we", bus.we_o, 0);
      chk("rst_bus", {bus.adr_o, bus.dat_o, bus.sel_o}, 0);
      chk("rst_rsp", {bus.rsp_valid, bus.rsp_err, bus.rsp_rdata}, 0);
      chk("rst_ready", bus.req_ready, 1);
      chk("rst_busy", bus.busy_o, 0);
      rst = 1'b0;
      tick();

      // Write byte 0xA5 at 0xFF02, exact one-edge latency to cyc_o
      send(1'b1, 2'd0, 32'h0000_FF02, 32'h0000_00A5, 32'h0, 1'b0);
      chk("t1_cyc_pre", bus.cyc_o, 0);
      chk("t1_busy", bus.busy_o, 1);
      tick();
      chk("t1_cyc", {bus.cyc_o, bus.stb_o}, 2'b11);
      chk("t1_adr", bus.adr_o, 30'h3FC0);
      chk("t1_sel", bus.sel_o, 4'b0100);
      chk("t1_dat", bus.dat_o, 32'h00A5_0000);
      chk("t1_we", bus.we_o, 1);
      tick();
      chk("t1_hold_adr", bus.adr_o, 30'h3FC0);
      respond(1'b1, 1'b0, 32'hFFFF_FFFF);
      chk("t1_cyc_fall", bus.cyc_o, 0);
      take_rsp("t1");

      // Read half at 0x1002
      send(1'b0, 2'd1, 32'h0000_1002, 32'h0, 32'h0000_BEEF, 1'b0);
      wait_cyc("t2_cyc");
      chk("t2_sel", bus.sel_o, 4'b1100);
      chk("t2_adr", bus.adr_o, 30'h400);
      chk("t2_we", bus.we_o, 0);
      respond(1'b1, 1'b0, 32'hBEEF_1234);
      take_rsp("t2");

      // Read byte at 0x1003
      send(1'b0, 2'd0, 32'h0000_1003, 32'h0, 32'h0000_00BE, 1'b0);
      wait_cyc("t2b_cyc");
      chk("t2b_sel", bus.sel_o, 4'b1000);
      respond(1'b1, 1'b0, 32'hBEEF_1234);
      take_rsp("t2b");

      // Write byte at 0x2001: bytes outside the selected lane are zeroed
      send(1'b1, 2'd0, 32'h0000_2001, 32'h1234_ABCD, 32'h0, 1'b0);
      wait_cyc("t2c_cyc");
      chk("t2c_sel", bus.sel_o, 4'b0010);
      chk("t2c_dat", bus.dat_o, 32'h0000_CD00);
      respond(1'b1, 1'b0, 32'h0);
      take_rsp("t2c");

      // Misaligned word and illegal dword: no bus cycle, error response
      send(1'b0, 2'd2, 32'h0000_1001, 32'h0, 32'h0, 1'b1);
      saw_cyc = 1'b0;
      for (int i = 0; i < 3; i++) begin
         saw_cyc |= bus.cyc_o;
         tick();
      end
      chk("t3_no_cyc", saw_cyc, 0);
      take_rsp("t3");
      send(1'b0, 2'd3, 32'h0000_6000, 32'h0, 32'h0, 1'b1);
      saw_cyc = 1'b0;
      for (int i = 0; i < 3; i++) begin
         saw_cyc |= bus.cyc_o;
         tick();
      end
      chk("t3b_no_cyc", saw_cyc, 0);
      take_rsp("t3b");

      // Three back-to-back requests while the slave stalls
      drive(1'b1, 2'd2, 32'h0000_3000, 32'h1111_1111);
      tick();
      chk("t4_ready1", bus.req_ready, 1);
      drive(1'b0, 2'd2, 32'h0000_3004, 32'h0);
      tick();
      chk("t4_ready2", bus.req_ready, 1);
      drive(1'b1, 2'd0, 32'h0000_3009, 32'h0000_0077);
      tick();
      bus.req_valid = 1'b0;
      q.push_back('{rdata: 32'h0, err: 1'b0});
      q.push_back('{rdata: 32'h0, err: 1'b1});
      q.push_back('{rdata: 32'h0, err: 1'b0});
      chk("t4_full", bus.req_ready, 0);
      chk("t4_cyc", bus.cyc_o, 1);
      chk("t4_adr1", bus.adr_o, 30'hC00);
      tick();
      chk("t4_still_full", bus.req_ready, 0);
      respond(1'b1, 1'b0, 32'h0);
      take_rsp("t4_r1");
      wait_cyc("t4_cyc2");
      chk("t4_adr2", bus.adr_o, 30'hC01);
      chk("t4_ready_back", bus.req_ready, 1);
      respond(1'b1, 1'b1, 32'hDEAD_BEEF);
      take_rsp("t4_r2");
      wait_cyc("t4_cyc3");
      chk("t4_sel3", bus.sel_o, 4'b0010);
      chk("t4_dat3", bus.dat_o, 32'h0000_7700);
      respond(1'b1, 1'b0, 32'h0);
      take_rsp("t4_r3");

      // Strays with cyc_o low are ignored
      respond(1'b1, 1'b1, 32'h0);
      tick();
      chk("stray_rsp", bus.rsp_valid, 0);
      chk("stray_busy", bus.busy_o, 0);

      // Timeout after 4 cycles in BUS, then a normal request
      send(1'b0, 2'd2, 32'h0000_4000, 32'h0, 32'h0, 1'b1);
      hi = 0;
      for (int i = 0; i < 12; i++) begin
         tick();
         if (bus.cyc_o) hi++;
         else if (hi > 0) break;
      end
      chk("t5_cyc_cycles", hi, 4);
      take_rsp("t5");
      send(1'b0, 2'd2, 32'h0000_4004, 32'h0, 32'hCAFE_F00D, 1'b0);
      wait_cyc("t5b_cyc");
      respond(1'b1, 1'b0, 32'hCAFE_F00D);
      take_rsp("t5b");

      // Reset during BUS with one entry queued
      send(1'b1, 2'd2, 32'h0000_5000, 32'h1, 32'h0, 1'b0);
      send(1'b1, 2'd2, 32'h0000_5004, 32'h2, 32'h0, 1'b0);
      chk("t6_cyc", bus.cyc_o, 1);
      rst = 1'b1;
      tick();
      chk("t6_cyc_rst", bus.cyc_o, 0);
      chk("t6_rsp_rst", bus.rsp_valid, 0);
      chk("t6_ready_rst", bus.req_ready, 1);
      chk("t6_busy_rst", bus.busy_o, 0);
      rst = 1'b0;
      q.delete();
      saw_cyc = 1'b0;
      for (int i = 0; i < 4; i++) begin
         tick();
         saw_cyc |= bus.cyc_o | bus.rsp_valid;
      end
      chk("t6_flushed", saw_cyc, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
